store_buffer: RTL and testbench

- Small FIFO write buffer between the EX/MEM pipeline register and the data memory.
- Absorbs stores so a store never competes with a load for the single memory port.
- Drains buffered stores into the data memory in idle cycles.
- Resolves load/store hazards by full-word forwarding or by stalling the pipeline.

---
 rtl/store_buffer.sv | 144 ++++++++++++++
 tb/tb_store_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: small circular FIFO of pending stores sitting in front of the
// single-ported data memory. Loads get the memory port first; buffered stores
// drain on any cycle the port is not carrying a load. Loads that hit a
// buffered word either forward a full word or stall while the buffer drains.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [DM_ADDRESS-1:0]   Address,
  input  logic [DATA_W-1:0]       WD,
  input  logic [2:0]              Funct3,
  input  logic                    Fence,
  output logic [DATA_W-1:0]       RD,
  output logic                    Stall,
  output logic                    dm_MemRead,
  output logic                    dm_MemWrite,
  output logic [DM_ADDRESS-1:0]   dm_Address,
  output logic [DATA_W-1:0]       dm_WD,
  output logic [2:0]              dm_Funct3,
  input  logic [DATA_W-1:0]       dm_RD,
  output logic [$clog2(DEPTH):0]  Occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef struct packed {
    logic [DM_ADDRESS-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [2:0]            funct3;
  } entry_t;

  entry_t [DEPTH-1:0] entries;
  logic   [DEPTH-1:0] valid;
  logic   [PW-1:0]    head, tail, young;
  logic   [CW-1:0]    count;
  logic   [DATA_W-1:0] rdHold;
  logic   [DEPTH-1:0] matchVec;

  logic isLoad, isStore, anyMatch, fwdOk, conflict, fenceStall, fullStall;
  logic loadIssue, forward, drain, enq;
  entry_t youngEnt, headEnt;

  // Word-address compare against every slot; invalid slots never match.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign matchVec[i] = valid[i] &&
      (entries[i].addr[DM_ADDRESS-1:2] == Address[DM_ADDRESS-1:2]);
  end

  // Walk oldest to youngest so the last hit seen is the youngest matching store.
  always_comb begin
    anyMatch = 1'b0;
    young    = head;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count && matchVec[head + PW'(k)]) begin
        anyMatch = 1'b1;
        young    = head + PW'(k);
      end
    end
  end

  assign youngEnt = entries[young];
  assign headEnt  = entries[head];

  // Reset masks every request so nothing reaches memory during the reset cycle.
  assign isLoad     = MemRead & ~reset;
  assign isStore    = MemWrite & ~MemRead & ~reset;
  assign fwdOk      = anyMatch && (youngEnt.funct3 == F3_WORD) &&
                      (Funct3 == F3_WORD) && (youngEnt.addr == Address);
  assign conflict   = isLoad & anyMatch & ~fwdOk;
  assign fenceStall = Fence & (count != '0) & ~reset;
  assign fullStall  = isStore & (count == CW'(DEPTH));
  assign Stall      = fullStall | conflict | fenceStall;

  assign loadIssue  = isLoad & ~anyMatch & ~fenceStall;
  assign forward    = isLoad & fwdOk & ~fenceStall;
  assign drain      = (count != '0) & ~loadIssue & ~reset;
  assign enq        = isStore & ~Stall;
  assign Occupancy  = count;

  // Memory port mux: a load owns the port, otherwise the head store drains.
  always_comb begin
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_Address  = '0;
    dm_WD       = '0;
    dm_Funct3   = '0;
    if (loadIssue) begin
      dm_MemRead = 1'b1;
      dm_Address = Address;
      dm_Funct3  = Funct3;
    end else if (drain) begin
      dm_MemWrite = 1'b1;
      dm_Address  = headEnt.addr;
      dm_WD       = headEnt.data;
      dm_Funct3   = headEnt.funct3;
    end
  end

  // Load result: memory or forwarded word, otherwise hold the last result.
  always_comb begin
    RD = rdHold;
    if (loadIssue)    RD = dm_RD;
    else if (forward) RD = youngEnt.data;
  end

  // Register the load result so RD holds through stalls and idle cycles.
  always_ff @(posedge clk) begin
    if (reset) rdHold <= '0;
    else       rdHold <= RD;
  end

  // FIFO state: tail enqueues, head pops; count tracks the difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        entries[tail] <= '{addr: Address, data: WD, funct3: Funct3};
        valid[tail]   <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({enq, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test-plan steps followed by random traffic. The
// reference keeps a program-order queue of pending stores over a committed
// memory image; every load must return the architectural value.
module tb_store_buffer;
  localparam int DEPTH = 4, AW = 9, DW = 32;

  logic clk = 1'b0, reset = 1'b0, MemRead = 1'b0, MemWrite = 1'b0, Fence = 1'b0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] WD = '0;
  logic [2:0]    Funct3 = '0;
  logic [DW-1:0] RD, dm_WD;
  logic [DW-1:0] dm_RD = '0;
  logic          Stall, dm_MemRead, dm_MemWrite;
  logic [AW-1:0] dm_Address;
  logic [2:0]    dm_Funct3;
  logic [$clog2(DEPTH):0] Occupancy;

  store_buffer #(.DEPTH(DEPTH), .DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .WD(WD), .Funct3(Funct3), .Fence(Fence), .RD(RD),
    .Stall(Stall), .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
    .dm_Address(dm_Address), .dm_WD(dm_WD), .dm_Funct3(dm_Funct3),
    .dm_RD(dm_RD), .Occupancy(Occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    f;
  } st_t;

  st_t         q[$];
  logic [31:0] physMem[128];
  logic [31:0] modelMem[128];
  logic [31:0] expRd = '0;
  logic [31:0] lastRD;
  logic        lastStall, lastDmRead;
  int          checks = 0, errors = 0;
  logic [2:0]  ldF[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  stF[3] = '{3'd0, 3'd1, 3'd2};

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                        input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] m;
    case (f3[1:0])
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    m = m << {off, 3'b000};
    return (w & ~m) | ((d << {off, 3'b000}) & m);
  endfunction

  // Architectural value: committed memory with every pending store applied in order.
  function automatic logic [31:0] archLoad(input logic [AW-1:0] a, input logic [2:0] f3);
    logic [31:0] w;
    w = modelMem[a[AW-1:2]];
    foreach (q[i]) if (q[i].a[AW-1:2] == a[AW-1:2]) w = merge(w, q[i].a[1:0], q[i].f, q[i].d);
    return extract(w, a[1:0], f3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic mr, input logic mw, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [2:0] f3, input logic fe);
    logic ld, st, anyM, fwd, fenceS, eStall, issue, drn, wr;
    int   yi;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [2:0]    wf;
    @(negedge clk);
    reset = 1'b0; MemRead = mr; MemWrite = mw; Address = a; WD = d; Funct3 = f3; Fence = fe;
    #1;
    dm_RD = extract(physMem[dm_Address[AW-1:2]], dm_Address[1:0], dm_Funct3);
    #1;
    ld = mr; st = mw && !mr; anyM = 1'b0; yi = 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!anyM && q[i].a[AW-1:2] == a[AW-1:2]) begin anyM = 1'b1; yi = i; end
    fwd    = anyM && q[yi].f == 3'd2 && f3 == 3'd2 && q[yi].a == a;
    fenceS = fe && q.size() > 0;
    eStall = (st && q.size() == DEPTH) || (ld && anyM && !fwd) || fenceS;
    issue  = ld && !anyM && !fenceS;
    drn    = q.size() > 0 && !issue;
    if (issue || (ld && fwd && !fenceS)) expRd = archLoad(a, f3);
    chk("stall", Stall, eStall);
    chk("rd", RD, expRd);
    chk("dmRead", dm_MemRead, issue);
    chk("dmWrite", dm_MemWrite, drn);
    if (issue) begin
      chk("ldAddr", dm_Address, a);
      chk("ldF3", dm_Funct3, f3);
    end else if (drn) begin
      chk("drAddr", dm_Address, q[0].a);
      chk("drData", dm_WD, q[0].d);
      chk("drF3", dm_Funct3, q[0].f);
    end else begin
      chk("idleAddr", dm_Address, 0);
      chk("idleWD", dm_WD, 0);
    end
    lastRD = RD; lastStall = Stall; lastDmRead = dm_MemRead;
    wr = dm_MemWrite; wa = dm_Address; wd = dm_WD; wf = dm_Funct3;
    @(posedge clk);
    if (wr) physMem[wa[AW-1:2]] = merge(physMem[wa[AW-1:2]], wa[1:0], wf, wd);
    if (drn) begin
      modelMem[q[0].a[AW-1:2]] = merge(modelMem[q[0].a[AW-1:2]], q[0].a[1:0], q[0].f, q[0].d);
      void'(q.pop_front());
    end
    if (st && !eStall) q.push_back('{a: a, d: d, f: f3});
    #1;
    chk("occ", Occupancy, 32'(q.size()));
  endtask

  task automatic rstCycle();
    @(negedge clk);
    reset = 1'b1; MemRead = 1'($urandom); MemWrite = 1'($urandom); Fence = 1'($urandom);
    Address = AW'($urandom); WD = $urandom; Funct3 = 3'd2;
    #1;
    chk("rstNoWrite", dm_MemWrite, 0);
    @(posedge clk);
    #1;
    q.delete();
    expRd = '0;
    chk("rstOcc", Occupancy, 0);
  endtask

  task automatic drainAll();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step(0, 0, '0, '0, 3'd0, 1'b1);
    chk("drained", Occupancy, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      physMem[i]  = $urandom;
      modelMem[i] = physMem[i];
    end
    rstCycle();
    step(0, 0, '0, '0, 3'd0, 0);
    chk("tpRstStall", lastStall, 0);
    chk("tpRstRD", lastRD, 0);

    // Single store, then drain on an idle cycle.
    step(0, 1, 9'h010, 32'hDEADBEEF, 3'd2, 0);
    chk("tpOcc1", Occupancy, 1);
    step(0, 0, '0, '0, 3'd0, 0);
    step(0, 0, '0, '0, 3'd0, 0);
    chk("tpMem010", physMem[9'h010 >> 2], 32'hDEADBEEF);

    // Stores interleaved with unrelated loads; loads hold off the drain.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 9'h100 + 9'(4 * i), 32'h1111_0000 + i, 3'd2, 0);
      step(1, 0, 9'h040 + 9'(4 * i), '0, 3'd2, 0);
    end
    drainAll();

    // Full-word forward.
    step(0, 1, 9'h020, 32'h12345678, 3'd2, 0);
    step(1, 0, 9'h020, '0, 3'd2, 0);
    chk("tpFwdRD", lastRD, 32'h12345678);
    chk("tpFwdStall", lastStall, 0);
    chk("tpFwdDmRd", lastDmRead, 0);

    // Byte load against a buffered word: one stall, then memory read.
    step(0, 1, 9'h020, 32'h000000F0, 3'd2, 0);
    step(1, 0, 9'h020, '0, 3'd0, 0);
    chk("tpLbStall", lastStall, 1);
    step(1, 0, 9'h020, '0, 3'd0, 0);
    chk("tpLbStall2", lastStall, 0);
    chk("tpLbDmRd", lastDmRead, 1);
    chk("tpLbRD", lastRD, 32'hFFFFFFF0);

    // Stores then fence until empty.
    step(0, 1, 9'h030, 32'hA0A0A0A0, 3'd2, 0);
    step(0, 1, 9'h034, 32'hB1B1B1B1, 3'd2, 0);
    step(0, 1, 9'h038, 32'hC2C2C2C2, 3'd2, 0);
    drainAll();
    step(0, 0, '0, '0, 3'd0, 1);
    chk("tpFenceDone", lastStall, 0);

    // Pending stores dropped by reset; later load sees prior contents.
    step(0, 1, 9'h050, 32'h55555555, 3'd2, 0);
    step(0, 1, 9'h054, 32'h66666666, 3'd2, 0);
    rstCycle();
    step(0, 0, '0, '0, 3'd0, 0);
    chk("tpRstIdleWr", dm_MemWrite, 0);
    step(1, 0, 9'h054, '0, 3'd2, 0);

    // Random traffic over a small address window to force hazards.
    for (int n = 0; n < 600; n++) begin
      int r;
      logic mr, mw, fe;
      logic [2:0] f3;
      logic [AW-1:0] a;
      r = $urandom_range(0, 99);
      if (r < 1) rstCycle();
      else begin
        mr = (r < 40);
        mw = (r >= 32 && r < 80);
        fe = (r >= 92);
        f3 = mr ? ldF[$urandom_range(0, 4)] : stF[$urandom_range(0, 2)];
        a  = AW'($urandom_range(0, 47));
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
        step(mr, mw, a, $urandom, f3, fe);
      end
    end
    drainAll();
    for (int i = 0; i < 16; i++) chk("finalMem", physMem[i], modelMem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
